// File: rtl/unsigned_mul_8x8_ha_array_reduce_pipe_if.sv
// rtl/unsigned_mul_8x8_ha_array_reduce_pipe_if.sv - row-pair input and product output handshake bundle
// master drives the row pairs and out_ready; slave is the reduction pipe.
interface unsigned_mul_8x8_ha_array_reduce_pipe_if #(
  parameter int TW = 9,
  parameter int BW = 7,
  parameter int PW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] ha_array_0_t;
  logic [TW-1:0] ha_array_1_t;
  logic [TW-1:0] ha_array_2_t;
  logic [TW-1:0] ha_array_3_t;
  logic [BW-1:0] ha_array_0_b;
  logic [BW-1:0] ha_array_1_b;
  logic [BW-1:0] ha_array_2_b;
  logic [BW-1:0] ha_array_3_b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] p;
  logic          p_ovf;

  modport master (
    output in_valid, ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
           ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b, out_ready,
    input  in_ready, out_valid, p, p_ovf
  );

  modport slave (
    input  in_valid, ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
           ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b, out_ready,
    output in_ready, out_valid, p, p_ovf
  );
endinterface

// File: rtl/unsigned_mul_8x8_ha_array_reduce_pipe.sv
// rtl/unsigned_mul_8x8_ha_array_reduce_pipe.sv - two-stage reduction of four HA row pairs to a 16-bit product
// Define MUL_REDUCE_SAT_EN for a saturating product; default wraps to 16 bits.
module unsigned_mul_8x8_ha_array_reduce_pipe (
  input  logic clk,
  input  logic rst_n,
  unsigned_mul_8x8_ha_array_reduce_pipe_if.slave bus
);
  localparam int B_OFFSET  = 2;
  localparam int ROW_SHIFT = 2;
  localparam int PW        = 16;
  localparam int RW        = 10;
  localparam int SW        = 13;
  localparam int XW        = PW + 1;

  logic [RW-1:0] r0, r1, r2, r3;
  logic [SW-1:0] s01_d, s23_d;
  logic [SW-1:0] s01_q, s23_q;
  logic [XW-1:0] sum;
  logic [PW-1:0] p_d;
  logic          v1, v2;
  logic          en1, en2;

  // Each row pair: b sits B_OFFSET bits above t.
  assign r0 = RW'(bus.ha_array_0_t) + (RW'(bus.ha_array_0_b) << B_OFFSET);
  assign r1 = RW'(bus.ha_array_1_t) + (RW'(bus.ha_array_1_b) << B_OFFSET);
  assign r2 = RW'(bus.ha_array_2_t) + (RW'(bus.ha_array_2_b) << B_OFFSET);
  assign r3 = RW'(bus.ha_array_3_t) + (RW'(bus.ha_array_3_b) << B_OFFSET);

  assign s01_d = SW'(r0) + (SW'(r1) << ROW_SHIFT);
  assign s23_d = SW'(r2) + (SW'(r3) << ROW_SHIFT);
  assign sum   = XW'(s01_q) + (XW'(s23_q) << (2 * ROW_SHIFT));

  always_comb begin
    p_d = sum[PW-1:0];
`ifdef MUL_REDUCE_SAT_EN
    if (sum[PW]) p_d = '1;
`endif
  end

  // A stage may load when it is empty or its successor is loading this cycle.
  assign en2          = !v2 || bus.out_ready;
  assign en1          = !v1 || en2;
  assign bus.in_ready = en1;
  assign bus.out_valid = v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      s01_q     <= '0;
      s23_q     <= '0;
      bus.p     <= '0;
      bus.p_ovf <= 1'b0;
    end else begin
      if (en1) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          s01_q <= s01_d;
          s23_q <= s23_d;
        end
      end
      if (en2) begin
        v2 <= v1;
        if (v1) begin
          bus.p     <= p_d;
          bus.p_ovf <= sum[PW];
        end
      end
    end
  end
endmodule
